// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, PC increment and fetch FSM states.
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Fetch front end: owns the fetch PC, issues one-outstanding instruction requests,
// fills the IF/ID registers and kills in-flight fetches on a redirect.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int               XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            im_req_valid_o,
  input  logic            im_req_ready_i,
  output logic [XLEN-1:0] im_req_addr_o,
  input  logic            im_rsp_valid_i,
  input  logic [XLEN-1:0] im_rsp_data_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_inst_o
);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_next_pc;
  logic            r_kill;
  logic [XLEN-1:0] r_buf;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_inst;

  logic            w_out_free;
  logic            w_load;
  logic [XLEN-1:0] w_load_inst;
  logic            w_discard;
  logic            w_capture;
  logic            w_arm_kill;

  assign w_out_free     = !r_if_valid || !stall_i;
  assign im_req_valid_o = (r_state == REQ);
  assign im_req_addr_o  = r_req_addr;
  assign if_valid_o     = r_if_valid;
  assign if_pc_o        = r_if_pc;
  assign if_inst_o      = r_if_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_next_state;
  end

  // A redirect without a response in hand cannot cancel the issued request, so it arms the kill.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_inst  = r_buf;
    w_discard    = 1'b0;
    w_capture    = 1'b0;
    w_arm_kill   = 1'b0;
    case (r_state)
      BOOT: w_next_state = REQ;
      REQ: begin
        w_arm_kill = redirect_i;
        if (im_req_ready_i) w_next_state = WAIT;
      end
      WAIT: begin
        if (im_rsp_valid_i) begin
          if (r_kill || redirect_i) begin
            w_discard    = 1'b1;
            w_next_state = REQ;
          end else if (w_out_free) begin
            w_load       = 1'b1;
            w_load_inst  = im_rsp_data_i;
            w_next_state = REQ;
          end else begin
            w_capture    = 1'b1;
            w_next_state = HOLD;
          end
        end else begin
          w_arm_kill = redirect_i;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          w_next_state = REQ;
        end else if (w_out_free) begin
          w_load       = 1'b1;
          w_next_state = REQ;
        end
      end
      default: w_next_state = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_addr <= RESET_PC;
      r_next_pc  <= RESET_PC;
      r_kill     <= 1'b0;
      r_buf      <= '0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else begin
      if (w_arm_kill) begin
        r_kill    <= 1'b1;
        r_next_pc <= redirect_pc_i;
      end
      if (w_discard) begin
        r_kill     <= 1'b0;
        r_req_addr <= redirect_i ? redirect_pc_i : r_next_pc;
      end
      if (w_capture) r_buf <= im_rsp_data_i;
      if (w_load) begin
        r_if_pc    <= r_req_addr;
        r_if_inst  <= w_load_inst;
        r_req_addr <= r_req_addr + XLEN'(PC_STEP);
      end
      if (redirect_i && (r_state == BOOT || r_state == HOLD)) r_req_addr <= redirect_pc_i;
      if (redirect_i)    r_if_valid <= 1'b0;
      else if (w_load)   r_if_valid <= 1'b1;
      else if (!stall_i) r_if_valid <= 1'b0;
    end
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch front end of the pipelined RV32 core. It owns the architectural fetch PC and issues one-outstanding fetch requests to the instruction-memory port. It buffers returned instructions into the IF/ID boundary and redirects on the taken-control-flow decision from the PC-select logic downstream (branch, JAL/JALR, interrupt entry, mret). Redirects kill any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, address of the first fetch after reset
- `XLEN`, 32, address/instruction width
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `redirect_i`  in  1  taken control transfer this cycle (PC-select output)
- `redirect_pc_i`  in  XLEN  target for `redirect_i` (already muxed: branch/jump/ISR/mepc)
- `stall_i`  in  1  IF/ID cannot accept (hazard unit); holds `if_*` outputs
- `im_req_valid_o`  out  1  fetch request valid
- `im_req_ready_i`  in  1  memory accepts request
- `im_req_addr_o`  out  XLEN  fetch address, stable while valid && !ready
- `im_rsp_valid_i`  in  1  instruction data returned (one per accepted request)
- `im_rsp_data_i`  in  XLEN  instruction word
- `if_valid_o`  out  1  `if_inst_o`/`if_pc_o` hold a live instruction
- `if_pc_o`  out  XLEN  PC of `if_inst_o`
- `if_inst_o`  out  XLEN  fetched instruction

## Operation
- Registers: `state_q`, `req_addr_q` (address of current/next request), `next_pc_q` (pending redirect target), `kill_q`, `buf_q` (HOLD instruction), `if_*` output regs.
- "Out free" = `!if_valid_o || !stall_i`.
- BOOT: entered on reset; `im_req_valid_o`=0; → REQ next cycle.
- REQ: `im_req_valid_o`=1, `im_req_addr_o`=`req_addr_q`. Accept (valid && ready) → WAIT.
- WAIT: on `im_rsp_valid_i`:
  - `kill_q` or `redirect_i` → discard data, clear `kill_q`, `req_addr_q` ← (`redirect_i` ? `redirect_pc_i` : `next_pc_q`), → REQ.
  - else if out free → `if_*` ← {1, `req_addr_q`, data}, `req_addr_q` += 4, → REQ.
  - else `buf_q` ← data, → HOLD.
- HOLD: out free → `if_*` ← {1, `req_addr_q`, `buf_q`}, `req_addr_q` += 4, → REQ.
- Redirect rules (priority over everything except reset):
  - `if_valid_o` ← 0 next cycle, even if `stall_i`=1.
  - In REQ or WAIT without a response this cycle: `kill_q` ← 1, `next_pc_q` ← `redirect_pc_i`. `im_req_addr_o` does not change while unaccepted; the stale request completes and its response is discarded.
  - In HOLD: drop `buf_q`, `req_addr_q` ← `redirect_pc_i`, → REQ.
  - In BOOT: `req_addr_q` ← `redirect_pc_i`.
- A second redirect while `kill_q`=1 overwrites `next_pc_q`; only the latest target is fetched.
- `stall_i` with `if_valid_o`=0 has no effect; output loads normally.
- PC arithmetic: modulo 2^XLEN, so 32'hFFFF_FFFC + 4 = 0. Misaligned targets are passed through unchanged; alignment traps are handled elsewhere.

## Timing
- Reset values: state BOOT, `req_addr_q`=`RESET_PC`, `kill_q`=0, `im_req_valid_o`=0, `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0, `buf_q`=0.
- First request valid in the 2nd rising edge after `rst_n` release (BOOT for one cycle).
- The memory port carries one outstanding request at a time. The response may arrive no earlier than the cycle after acceptance.
- Best case, with ready in REQ and the response on the next cycle:
  - accept at cycle N, response at N+1, `if_valid_o` at N+2, next request valid at N+2.
  - Peak throughput is one instruction per 2 cycles.
- `redirect_i` takes effect on the same edge; the target request is valid no later than the cycle after the killed response returns.
- `rst_n` asserted mid-transaction: all state cleared immediately. The memory adapter is reset by the same `rst_n`, so no orphan response is expected.

## Structure
- Shared `cpu_pkg`: `fetch_state_e` {BOOT, REQ, WAIT, HOLD}, `XLEN`, `PC_STEP` (=4), default `RESET_PC`.
- Single flat module. The FSM plus output/buffer registers do not justify a sub-module.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100, zero-latency memory → requests to 0x100, 0x104, 0x108; `if_pc_o` follows with `if_valid_o` every 2nd cycle.
- `stall_i`=1 for 5 cycles while a response arrives → HOLD entered, `if_inst_o` unchanged. Buffered word appears the cycle after stall drops; no word is lost or duplicated.
- `redirect_i` with target 0x200 while in WAIT, response 3 cycles later → response discarded, `if_valid_o`=0, next request address 0x200.
- `redirect_i` in REQ with `im_req_ready_i`=0 for 4 cycles → `im_req_addr_o` stays at the old address until accepted, response dropped, then fetch from the target.
- Two redirects, to 0x300 then 0x400, during one WAIT → only 0x400 fetched.
- `req_addr_q`=32'hFFFF_FFFC sequential fetch → next request 32'h0000_0000. Assert `rst_n` mid-WAIT → all outputs at reset values immediately.
